// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input and reports them with direction and timeout.
// Latency: valid strobes SYNC_STAGES+FILTER_LEN+1 clks after the completing rising edge is first sampled.
// Backpressure: none; results are held between valid strobes and each strobe lasts one cycle.
module pwm_capture #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             dir,
    output logic             valid,
    output logic             timeout
);

    localparam int unsigned     FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0]   RUN_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] TMO     = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [FW-1:0]          run;
    logic                   filt;
    logic                   filt_q;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    logic [WIDTH-1:0]       cnt_per;
    logic [WIDTH-1:0]       cnt_hi;
    logic [WIDTH-1:0]       per_m1;
    logic                   per_done;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Any sample agreeing with the current level restarts the run, so only a
    // clean stretch of FILTER_LEN differing samples moves the filtered level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b0;
            run  <= '0;
        end else if (sync_lvl != filt) begin
            if (run == RUN_LAST) begin
                filt <= sync_lvl;
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end else begin
            run <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            filt_q <= filt;
            rise   <= filt & ~filt_q;
            fall   <= ~filt & filt_q;
        end
    end

    assign per_m1   = cnt_per - 1'b1;
    assign per_done = (cnt_per == TMO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt_per    <= '0;
            cnt_hi     <= '0;
            period     <= '0;
            duty_cycle <= '0;
            dir        <= 1'b0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                cnt_per <= '0;
                cnt_hi  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_per <= '0;
                        cnt_hi  <= '0;
                        if (rise) begin
                            state   <= HIGH;
                            cnt_per <= WIDTH'(1);
                            cnt_hi  <= WIDTH'(1);
                        end
                    end
                    HIGH: begin
                        if (per_done) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            cnt_per <= '0;
                            cnt_hi  <= '0;
                        end else begin
                            cnt_per <= cnt_per + 1'b1;
                            // The falling-edge cycle already belongs to the low phase.
                            if (fall) begin
                                state <= LOW;
                            end else begin
                                cnt_hi <= cnt_hi + 1'b1;
                            end
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period     <= per_m1;
                            duty_cycle <= cnt_hi;
                            dir        <= (cnt_hi >= (per_m1 >> 1));
                            valid      <= 1'b1;
                            timeout    <= 1'b0;
                            state      <= HIGH;
                            cnt_per    <= WIDTH'(1);
                            cnt_hi     <= WIDTH'(1);
                        end else if (per_done) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                            cnt_per <= '0;
                            cnt_hi  <= '0;
                        end else begin
                            cnt_per <= cnt_per + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt_per <= '0;
                        cnt_hi  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM patterns with hand-computed period/duty/dir.
module tb_pwm_capture;

    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] duty_cycle;
    logic        dir;
    logic        valid;
    logic        timeout;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int d_cyc;

    typedef struct {
        int          cyc;
        logic [15:0] per;
        logic [15:0] duty;
        logic        dir;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    pwm_capture #(
        .WIDTH      (16),
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .period    (period),
        .duty_cycle(duty_cycle),
        .dir       (dir),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected measurement.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=%b at cycle %0d expected no strobe", valid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid_cycle", cyc, mon_e.cyc);
                chk("period", {16'd0, period}, {16'd0, mon_e.per});
                chk("duty_cycle", {16'd0, duty_cycle}, {16'd0, mon_e.duty});
                chk("dir", {31'd0, dir}, {31'd0, mon_e.dir});
                chk("timeout_at_valid", {31'd0, timeout}, {31'd0, mon_e.tmo});
            end
        end
    end

    task automatic seg(input logic v, input logic en, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pwm_in = v;
            enable = en;
        end
    endtask

    task automatic pw(input int hi, input int lo);
        seg(1'b1, 1'b1, hi);
        seg(1'b0, 1'b1, lo);
    endtask

    // Call right before the rising edge that completes a measurement.
    task automatic expect_meas(input logic [15:0] per, input logic [15:0] duty,
                               input logic d, input logic t);
        exp_t e;
        e.cyc  = cyc + 9;
        e.per  = per;
        e.duty = duty;
        e.dir  = d;
        e.tmo  = t;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        pwm_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("reset_period", {16'd0, period}, 32'd0);
        chk("reset_duty", {16'd0, duty_cycle}, 32'd0);
        chk("reset_dir", {31'd0, dir}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        seg(1'b0, 1'b1, 20);

        // 1000/300: first rise only starts a measurement
        pw(300, 700);
        for (int k = 0; k < 3; k++) begin
            expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
            pw(300, 700);
        end

        // duty sweep around the 50% threshold (999 >> 1 = 499)
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        pw(700, 300);
        expect_meas(16'd999, 16'd700, 1'b1, 1'b0);
        pw(498, 502);
        expect_meas(16'd999, 16'd498, 1'b0, 1'b0);
        pw(499, 501);
        expect_meas(16'd999, 16'd499, 1'b1, 1'b0);
        pw(500, 500);

        // 3-clk glitch inside 300-clk high is filtered out
        expect_meas(16'd999, 16'd500, 1'b1, 1'b0);
        seg(1'b1, 1'b1, 150);
        seg(1'b0, 1'b1, 3);
        seg(1'b1, 1'b1, 147);
        seg(1'b0, 1'b1, 700);
        // 4-clk glitch is a real edge: 104-clk period with 100 high, then 896/196
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        seg(1'b1, 1'b1, 100);
        seg(1'b0, 1'b1, 4);
        expect_meas(16'd103, 16'd100, 1'b1, 1'b0);
        seg(1'b1, 1'b1, 196);
        seg(1'b0, 1'b1, 700);
        expect_meas(16'd895, 16'd196, 1'b0, 1'b0);
        pw(300, 700);

        // pwm_in stuck high: timeout exactly TMO clks after the filtered rise
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        d_cyc = cyc + 1;
        seg(1'b1, 1'b1, TMO + 8);
        @(negedge clk);
        chk("timeout_cycle_before", {31'd0, timeout}, 32'd0);
        chk("timeout_probe_cycle", cyc, d_cyc + 7 + TMO);
        @(negedge clk);
        chk("timeout_set", {31'd0, timeout}, 32'd1);
        chk("timeout_period_held", {16'd0, period}, 32'd999);
        chk("timeout_duty_held", {16'd0, duty_cycle}, 32'd300);
        seg(1'b0, 1'b1, 700);
        pw(300, 700);
        chk("timeout_sticky", {31'd0, timeout}, 32'd1);
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        pw(300, 700);

        // reset mid-HIGH clears everything asynchronously
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        seg(1'b1, 1'b1, 100);
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        #1;
        chk("async_rst_period", {16'd0, period}, 32'd0);
        chk("async_rst_duty", {16'd0, duty_cycle}, 32'd0);
        chk("async_rst_dir", {31'd0, dir}, 32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_timeout", {31'd0, timeout}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seg(1'b0, 1'b1, 20);
        pw(300, 700);
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        pw(300, 700);

        // enable dropped for 50 clks mid-LOW aborts the measurement
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        seg(1'b1, 1'b1, 300);
        seg(1'b0, 1'b1, 100);
        seg(1'b0, 1'b0, 50);
        chk("en_low_valid", {31'd0, valid}, 32'd0);
        chk("en_low_period_held", {16'd0, period}, 32'd999);
        chk("en_low_duty_held", {16'd0, duty_cycle}, 32'd300);
        chk("en_low_timeout_held", {31'd0, timeout}, 32'd0);
        seg(1'b0, 1'b1, 550);
        pw(300, 700);
        // enable low exactly on the completing-rise cycle: no update
        seg(1'b1, 1'b1, 7);
        seg(1'b1, 1'b0, 1);
        seg(1'b1, 1'b1, 292);
        seg(1'b0, 1'b1, 700);
        pw(300, 700);
        expect_meas(16'd999, 16'd300, 1'b0, 1'b0);
        pw(300, 700);
        seg(1'b0, 1'b1, 30);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
